fetch_stage_unit: RTL
=====================

Name: fetch_stage_unit

Overview:
Consumer end of the hazard-detection handshake. Owns the PC register and the IF/ID pipeline register, and obeys PCWrite, IF_ID_Write and the EX-stage redirect (branch/jump taken): hold, advance or flush. Sits between the instruction memory and the ID stage. Also keeps stall/flush performance counters and a stuck-stall watchdog.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CW, 16, width of the stall and flush counters
MAX_STALL, 8, consecutive stall cycles that trip the watchdog (range 1..255)

Ports:
Clk  input  1  clock; all state updates on the rising edge
Rst  input  1  synchronous reset, active-low
PCWrite  input  1  1 = PC may advance; 0 = hold PC
IF_ID_Write  input  1  1 = IF/ID may load; 0 = hold IF/ID
Redirect_Ex  input  1  branch/jump taken in EX; load target, flush IF/ID
Target_Ex  input  32  redirect target address
Instruction_IF  input  32  instruction memory data for PC_IF (combinational)
PC_IF  output  32  current fetch address (registered PC)
Instruction_ID  output  32  IF/ID instruction
PCPlus4_ID  output  32  IF/ID PC+4
Valid_ID  output  1  1 = IF/ID holds a real instruction; 0 = bubble
MisalignedTarget  output  1  one-cycle pulse: last redirect had Target_Ex[1:0] != 0
StallCount  output  CW  saturating count of stall cycles
FlushCount  output  CW  saturating count of redirect cycles
StallTimeout  output  1  sticky watchdog flag
State  output  2  action taken last cycle: 00 RUN, 01 STALL, 10 REDIRECT

Behaviour:
- Reset (Rst==0 at an edge) sets:
  - PC_IF=RESET_PC
  - Instruction_ID=0, PCPlus4_ID=0, Valid_ID=0
  - MisalignedTarget=0, StallCount=0, FlushCount=0, StallTimeout=0
  - State=RUN, internal consecutive-stall counter=0
- Reset overrides every other input, including mid-stall or mid-redirect.
- Per-edge priority, highest first:
  1. Redirect_Ex=1:
     - PC_IF <= {Target_Ex[31:2],2'b00}
     - IF/ID flushed: Instruction_ID=0 (nop), PCPlus4_ID=0, Valid_ID=0
     - State=REDIRECT; FlushCount+1
     - MisalignedTarget <= (Target_Ex[1:0]!=0)
     - PCWrite and IF_ID_Write are ignored.
  2. Otherwise, PC update: PCWrite=1 → PC_IF <= PC_IF+4 (mod 2^32, FFFF_FFFC wraps to 0); PCWrite=0 → PC_IF holds.
  3. Otherwise, IF/ID update: IF_ID_Write=1 → Instruction_ID <= Instruction_IF, PCPlus4_ID <= PC_IF+4, Valid_ID <= 1; IF_ID_Write=0 → IF/ID holds all three.
- A stall cycle is one where Redirect_Ex=0 and PCWrite=0. It sets State=STALL and increments StallCount. Otherwise State=RUN.
- PCWrite and IF_ID_Write disagreeing is legal; they are applied independently. Stall classification uses PCWrite only.
- MisalignedTarget is 0 on every non-redirect cycle.
- Counters saturate at 2^CW-1 and never wrap.
- Watchdog:
  - The internal counter increments on each stall cycle and clears on any non-stall cycle.
  - When it reaches MAX_STALL, StallTimeout sets and stays 1 until reset.
  - The internal counter saturates at MAX_STALL.
- Latency: one cycle from an input to its effect on outputs. PC_IF feeds instruction memory directly, so Instruction_IF is consumed in the same cycle.

Test Plan:
- Reset with RESET_PC=0x100, then 3 edges with PCWrite=IF_ID_Write=1 and Instruction_IF=0xAAAA0000+PC → PC_IF 0x104, 0x108, 0x10C. After the 3rd edge: Instruction_ID=0xAAAA0108, PCPlus4_ID=0x10C, Valid_ID=1, State=RUN.
- Two-cycle stall: PCWrite=IF_ID_Write=0 for 2 edges → PC_IF and IF/ID unchanged, State=STALL, StallCount=2. Next run edge resumes at PC+4.
- Redirect during stall: PCWrite=0, Redirect_Ex=1, Target_Ex=0x2003 → PC_IF=0x2000, Valid_ID=0, Instruction_ID=0, MisalignedTarget=1 for one cycle, FlushCount=1, State=REDIRECT.
- Watchdog with MAX_STALL=3:
  - 2 stalls, 1 run, 2 stalls → StallTimeout=0.
  - 3rd consecutive stall → StallTimeout=1; it stays 1 through later run cycles.
- Saturation with CW=2: 5 redirects → FlushCount=3. PC wrap: PC_IF=0xFFFF_FFFC plus a run edge → 0x0000_0000.
- Reset mid-stall: Rst=0 while PCWrite=0 and Redirect_Ex=1 → all outputs at reset values next cycle, PC_IF=RESET_PC.

Source files
------------

// File: rtl/fetch_stage_unit.sv
// Fetch stage: PC register and IF/ID pipeline register. It obeys the hazard unit's
// hold/advance controls and EX-stage redirects, and it keeps stall/flush counters and a stall watchdog.
module fetch_stage_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CW        = 16,
  parameter int          MAX_STALL = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          PCWrite,
  input  logic          IF_ID_Write,
  input  logic          Redirect_Ex,
  input  logic [31:0]   Target_Ex,
  input  logic [31:0]   Instruction_IF,
  output logic [31:0]   PC_IF,
  output logic [31:0]   Instruction_ID,
  output logic [31:0]   PCPlus4_ID,
  output logic          Valid_ID,
  output logic          MisalignedTarget,
  output logic [CW-1:0] StallCount,
  output logic [CW-1:0] FlushCount,
  output logic          StallTimeout,
  output logic [1:0]    State
);

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_STALL    = 2'b01,
    S_REDIRECT = 2'b10
  } act_e;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [7:0]    WD_MAX  = 8'(MAX_STALL);

  act_e          state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pcp4_q, pcp4_d;
  logic          vld_q, vld_d;
  logic          mis_q, mis_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;
  logic [7:0]    wd_q, wd_d;
  logic          tmo_q, tmo_d;
  logic [31:0]   pc_plus4;
  logic          stall;

  assign pc_plus4 = pc_q + 32'd4;
  assign stall    = !Redirect_Ex && !PCWrite;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      pcp4_q      <= '0;
      vld_q       <= 1'b0;
      mis_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wd_q        <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pcp4_q      <= pcp4_d;
      vld_q       <= vld_d;
      mis_q       <= mis_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wd_q        <= wd_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = S_RUN;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pcp4_d      = pcp4_q;
    vld_d       = vld_q;
    mis_d       = 1'b0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wd_d        = '0;

    if (Redirect_Ex) begin
      // A redirect wins over both write enables and turns IF/ID into a bubble.
      state_d = S_REDIRECT;
      pc_d    = {Target_Ex[31:2], 2'b00};
      instr_d = '0;
      pcp4_d  = '0;
      vld_d   = 1'b0;
      mis_d   = |Target_Ex[1:0];
      if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
    end else begin
      if (PCWrite) pc_d = pc_plus4;
      if (IF_ID_Write) begin
        instr_d = Instruction_IF;
        pcp4_d  = pc_plus4;
        vld_d   = 1'b1;
      end
      if (stall) begin
        state_d = S_STALL;
        if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
        wd_d = (wd_q >= WD_MAX) ? WD_MAX : wd_q + 8'd1;
      end
    end

    tmo_d = tmo_q || (wd_d >= WD_MAX);
  end

  assign PC_IF            = pc_q;
  assign Instruction_ID   = instr_q;
  assign PCPlus4_ID       = pcp4_q;
  assign Valid_ID         = vld_q;
  assign MisalignedTarget = mis_q;
  assign StallCount       = stall_cnt_q;
  assign FlushCount       = flush_cnt_q;
  assign StallTimeout     = tmo_q;
  assign State            = state_q;

endmodule
